shift_prio_unit: RTL and testbench
==================================

SHIFT_PRIO_UNIT -- requirements
Module: shift_prio_unit

Interface
REQ-001 Parameter WIDTH, default 8, register width; SHALL be >= 2.
REQ-002 Parameter RST_VAL, default 8'h09 (zero-extended to WIDTH), register reset value.
REQ-003 Derived constant SEL_W = $clog2(WIDTH); SHALL NOT be overridable.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 cmd_valid  in  1  command request.
REQ-007 cmd_ready  out  1  unit accepts a command this cycle.
REQ-008 cmd_op  in  3  operation code.
REQ-009 cmd_amt  in  SEL_W  shift/rotate step count.
REQ-010 cmd_data  in  WIDTH  load value.
REQ-011 sel  in  SEL_W  bit-select index.
REQ-012 q  out  WIDTH  register contents.
REQ-013 done  out  1  one-cycle completion pulse.
REQ-014 bit_out  out  1  q[sel].
REQ-015 enc_idx  out  SEL_W  index of highest set bit of q.
REQ-016 enc_valid  out  1  q nonzero.

Function
REQ-017 Ops: 000 LOAD, 001 SHL (zero fill), 010 SHR (zero fill), 011 ROL, 100 ROR, 101 ASR (MSB fill); 110/111 NOP.
REQ-018 FSM states IDLE, RUN, DONE; cmd_ready SHALL be 1 only in IDLE.
REQ-019 Accept = cmd_valid && cmd_ready at a rising edge; op and amt captured at accept.
REQ-020 IDLE->DONE on accept of LOAD, NOP, or any op with cmd_amt==0; LOAD writes q <= cmd_data at the accept edge.
REQ-021 IDLE->RUN on accept of a shift/rotate op with cmd_amt>0; remaining counter <= cmd_amt.
REQ-022 RUN: each edge applies one 1-bit step of the captured op to q and decrements remaining; when remaining==1 the step is applied and state -> DONE.
REQ-023 Command with amt k>0 SHALL occupy exactly k+2 cycles (accept, k RUN, DONE); zero-step commands occupy 2 cycles.
REQ-024 DONE: done=1 for exactly one cycle, q held, state -> IDLE next edge.
REQ-025 q SHALL change only at LOAD accept or RUN steps; cmd_* ignored outside IDLE.
REQ-026 bit_out = q[sel], combinational; sel >= WIDTH (non-power-of-2 WIDTH) SHALL yield 0.
REQ-027 enc_idx/enc_valid SHALL be computed from q, priority MSB > ... > LSB; q==0 gives enc_idx=0, enc_valid=0.
REQ-028 Back-to-back: a command presented while in DONE SHALL be accepted at the edge after DONE (first IDLE cycle).

Reset
REQ-029 On rst at an edge: q <= RST_VAL, state IDLE, remaining 0, done 0; cmd_ready=1 the following cycle.
REQ-030 rst during RUN/DONE SHALL abandon the command with no done pulse; rst has priority over accept.

Configuration
REQ-031 Macro SHIFT_PRIO_PIPE_EN defined: enc_idx/enc_valid registered, reflecting q of the previous cycle (+1 cycle latency), reset to 0/0.
REQ-032 SHIFT_PRIO_PIPE_EN undefined: enc_idx/enc_valid combinational from current q (0 latency).

Structure
REQ-033 Package shift_prio_pkg SHALL hold the op enum (3-bit) and FSM state enum.
REQ-034 Sub-module prio_enc (param WIDTH; in vec, out idx, valid) SHALL implement the priority encoder; instantiated once.

Verification (WIDTH=8, RST_VAL=8'h09, macro undefined unless stated)
REQ-035 rst=1 one edge -> q=8'h09, enc_idx=3, enc_valid=1, cmd_ready=1, done=0.
REQ-036 LOAD 8'hA5 -> q=8'hA5 after accept edge, done high exactly 1 cycle, cmd_ready back in 2 cycles; sel=5 -> bit_out=1.
REQ-037 q=8'h81, ROL amt=3 -> q goes 03,06,0C on successive edges; done in cycle 5 counting accept as cycle 1.
REQ-038 q=8'h80, ASR amt=2 -> q=8'hE0; then SHR amt=7 -> q=8'h01, enc_idx=0, enc_valid=1.
REQ-039 ROR amt=4 in progress, rst asserted after 2 steps -> q=8'h09, no done pulse, new command accepted next cycle.
REQ-040 Macro defined: LOAD 8'h00 then LOAD 8'h40 -> enc_valid=0 until one cycle after q=8'h40, then enc_idx=6, enc_valid=1.

Source files
------------

// File: rtl/shift_prio_pkg.sv
// Shared types for shift_prio_unit: the command opcode and the control FSM states.
// The optional SHIFT_PRIO_PIPE_EN macro is consumed by shift_prio_unit only.
package shift_prio_pkg;

  typedef enum logic [2:0] {
    OP_LOAD    = 3'b000,
    OP_SHL     = 3'b001,
    OP_SHR     = 3'b010,
    OP_ROL     = 3'b011,
    OP_ROR     = 3'b100,
    OP_ASR     = 3'b101,
    OP_NOP     = 3'b110,
    OP_NOP_ALT = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // True for the ops that step q one bit per RUN cycle.
  function automatic logic is_step_op(input logic [2:0] op);
    return (op >= 3'(OP_SHL)) && (op <= 3'(OP_ASR));
  endfunction

endpackage

// File: rtl/prio_enc.sv
// MSB-first priority encoder: idx is the position of the highest set bit of vec,
// valid flags a nonzero vec (idx is 0 when vec is 0).
module prio_enc #(
  parameter int  WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Ascending scan so the last (highest) set bit wins.
  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

  assign valid = |vec;

endmodule

// File: rtl/shift_prio_unit.sv
// Multi-cycle shift/rotate register with bit-select and MSB priority encode of q.
// Define SHIFT_PRIO_PIPE_EN to register enc_idx/enc_valid (one cycle behind q).
module shift_prio_unit
  import shift_prio_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(8'h09),
  localparam int              SEL_W   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [SEL_W-1:0] cmd_amt,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] q,
  output logic             done,
  output logic             bit_out,
  output logic [SEL_W-1:0] enc_idx,
  output logic             enc_valid,
  output logic [1:0]       dbg_state
);

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE and all cmd_* inputs are ignored otherwise.

  state_e           r_state;
  op_e              r_op;
  logic [SEL_W-1:0] r_remaining;
  logic [WIDTH-1:0] r_q;
  logic             r_done;
  logic             r_ready;

  logic [SEL_W-1:0] w_enc_idx;
  logic             w_enc_valid;

  function automatic logic [WIDTH-1:0] step1(input op_e op, input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = v;
    case (op)
      OP_SHL:  r = {v[WIDTH-2:0], 1'b0};
      OP_SHR:  r = {1'b0, v[WIDTH-1:1]};
      OP_ROL:  r = {v[WIDTH-2:0], v[WIDTH-1]};
      OP_ROR:  r = {v[0], v[WIDTH-1:1]};
      OP_ASR:  r = {v[WIDTH-1], v[WIDTH-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_NOP;
      r_remaining <= '0;
      r_q         <= RST_VAL;
      r_done      <= 1'b0;
      r_ready     <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_op    <= op_e'(cmd_op);
            r_ready <= 1'b0;
            if (is_step_op(cmd_op) && (cmd_amt != '0)) begin
              r_state     <= ST_RUN;
              r_remaining <= cmd_amt;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              if (cmd_op == 3'(OP_LOAD)) r_q <= cmd_data;
            end
          end
        end
        ST_RUN: begin
          r_q         <= step1(r_op, r_q);
          r_remaining <= r_remaining - SEL_W'(1);
          if (r_remaining == SEL_W'(1)) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  prio_enc #(.WIDTH(WIDTH)) u_prio_enc (
    .vec   (r_q),
    .idx   (w_enc_idx),
    .valid (w_enc_valid)
  );

`ifdef SHIFT_PRIO_PIPE_EN
  logic [SEL_W-1:0] r_enc_idx;
  logic             r_enc_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_enc_idx   <= '0;
      r_enc_valid <= 1'b0;
    end else begin
      r_enc_idx   <= w_enc_idx;
      r_enc_valid <= w_enc_valid;
    end
  end

  assign enc_idx   = r_enc_idx;
  assign enc_valid = r_enc_valid;
`else
  assign enc_idx   = w_enc_idx;
  assign enc_valid = w_enc_valid;
`endif

  // Out-of-range selects (possible only for non-power-of-2 WIDTH) read as 0.
  assign bit_out   = (32'(sel) < WIDTH) ? r_q[sel] : 1'b0;
  assign q         = r_q;
  assign done      = r_done;
  assign cmd_ready = r_ready;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_shift_prio_unit.sv
// Bench for shift_prio_unit (WIDTH=8, RST_VAL=8'h09): cycle-level reference model
// plus directed command sequences with hand-computed results.
module tb_shift_prio_unit;

  localparam int W = 8;
  localparam logic [2:0] C_LOAD = 3'd0, C_SHL = 3'd1, C_SHR = 3'd2, C_ROL = 3'd3,
                         C_ROR  = 3'd4, C_ASR = 3'd5, C_NOP = 3'd6;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [2:0]   cmd_amt;
  logic [W-1:0] cmd_data;
  logic [2:0]   sel;
  logic [W-1:0] q;
  logic         done;
  logic         bit_out;
  logic [2:0]   enc_idx;
  logic         enc_valid;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  shift_prio_unit #(.WIDTH(W), .RST_VAL(8'h09)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_amt   (cmd_amt),
    .cmd_data  (cmd_data),
    .sel       (sel),
    .q         (q),
    .done      (done),
    .bit_out   (bit_out),
    .enc_idx   (enc_idx),
    .enc_valid (enc_valid),
    .dbg_state (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // After every edge the model holds the expected q/done/ready. An accepted
  // command is expanded into the list of future per-cycle (q, done) values.
  logic [W-1:0] exp_q[$];
  logic         done_q[$];
  int   m_q     = 0;
  logic m_done  = 1'b0;
  logic m_ready = 1'b0;
  logic m_on    = 1'b0;
  int   m_prev  = 0;
  int   mv      = 0;
  int   p_idx   = 0;
  logic p_valid = 1'b0;

  function automatic int step_val(input int op, input int v);
    case (op)
      1:       return (v * 2) % 256;
      2:       return v / 2;
      3:       return (v * 2) % 256 + v / 128;
      4:       return v / 2 + (v % 2) * 128;
      5:       return v / 2 + ((v >= 128) ? 128 : 0);
      default: return v;
    endcase
  endfunction

  function automatic int hi_idx(input int v);
    int t, n;
    t = v;
    n = 0;
    while (t > 1) begin
      t = t / 2;
      n++;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m_prev = m_q;
    if (rst) begin
      m_q = 9; m_done = 1'b0; m_ready = 1'b1; m_on = 1'b1;
      exp_q.delete(); done_q.delete();
      p_idx = 0; p_valid = 1'b0;
    end else if (m_on) begin
      if (exp_q.size() > 0) begin
        m_q = int'(exp_q.pop_front()); m_done = done_q.pop_front(); m_ready = 1'b0;
      end else if (m_ready && cmd_valid) begin
        if (cmd_op == C_LOAD) begin
          exp_q.push_back(cmd_data); done_q.push_back(1'b1);
        end else if (cmd_op >= C_SHL && cmd_op <= C_ASR && cmd_amt != 0) begin
          mv = m_q;
          for (int i = 0; i < int'(cmd_amt); i++) begin
            exp_q.push_back(W'(mv)); done_q.push_back(1'b0);
            mv = step_val(int'(cmd_op), mv);
          end
          exp_q.push_back(W'(mv)); done_q.push_back(1'b1);
        end else begin
          exp_q.push_back(W'(m_q)); done_q.push_back(1'b1);
        end
        m_q = int'(exp_q.pop_front()); m_done = done_q.pop_front(); m_ready = 1'b0;
      end else begin
        m_done = 1'b0; m_ready = 1'b1;
      end
      p_idx = hi_idx(m_prev); p_valid = (m_prev != 0);
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (m_on) begin
      check("q", q, m_q);
      check("done", done, m_done);
      check("cmd_ready", cmd_ready, m_ready);
      check("bit_out", bit_out, (m_q >> sel) % 2);
`ifdef SHIFT_PRIO_PIPE_EN
      check("enc_idx", enc_idx, p_idx);
      check("enc_valid", enc_valid, p_valid);
`else
      check("enc_idx", enc_idx, hi_idx(m_q));
      check("enc_valid", enc_valid, m_q != 0);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  // Returns #1 after the accept edge, i.e. early in the first post-accept cycle.
  task automatic send_cmd(input logic [2:0] op, input logic [2:0] amt, input logic [W-1:0] data);
    int   n;
    logic acc;
    n = 0;
    acc = 1'b0;
    @(negedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_amt = amt; cmd_data = data;
    while (!acc && n < 40) begin
      acc = (cmd_ready === 1'b1);
      @(posedge clk); #1;
      n++;
    end
    cmd_valid = 1'b0;
    if (!acc) check("accept_timeout", 32'(acc), 1);
  endtask

  // Cycle number (accept cycle = 1) in which done is seen high.
  task automatic wait_done(output int cyc);
    logic seen;
    cyc = 2;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
      else cyc++;
    end
    if (!seen) check("done_timeout", 32'(seen), 1);
  endtask

  // ---------------- directed sequence ----------------
  int cyc;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_amt = '0; cmd_data = '0; sel = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_q", q, 8'h09);
    check("rst_ready", cmd_ready, 1);
    check("rst_done", done, 0);
`ifndef SHIFT_PRIO_PIPE_EN
    check("rst_enc_idx", enc_idx, 3);
    check("rst_enc_valid", enc_valid, 1);
`endif

    // LOAD A5: two-cycle command, bit 5 set
    sel = 3'd5;
    send_cmd(C_LOAD, 3'd0, 8'hA5);
    check("load_q", q, 8'hA5);
    wait_done(cyc);
    check("load_done_cycle", cyc, 2);
    check("load_bit5", bit_out, 1);
    @(negedge clk);
    check("load_ready_back", cmd_ready, 1);

    // ROL 3 from 81: 03, 06, 0C, done in cycle 5
    send_cmd(C_LOAD, 3'd0, 8'h81);
    wait_done(cyc);
    send_cmd(C_ROL, 3'd3, 8'h00);
    @(posedge clk); #1; check("rol_step1", q, 8'h03);
    @(posedge clk); #1; check("rol_step2", q, 8'h06);
    @(posedge clk); #1; check("rol_step3", q, 8'h0C);
    check("rol_done_c5", done, 1);

    // Presented during DONE: accepted after the first IDLE cycle
    send_cmd(C_LOAD, 3'd0, 8'h80);
    wait_done(cyc);
    send_cmd(C_ASR, 3'd2, 8'h00);
    wait_done(cyc);
    check("asr_q", q, 8'hE0);
    check("asr_done_cycle", cyc, 4);
    send_cmd(C_SHR, 3'd7, 8'h00);
    wait_done(cyc);
    check("shr_q", q, 8'h01);
    check("shr_done_cycle", cyc, 9);
    @(negedge clk);
    check("shr_enc_idx", enc_idx, 0);
    check("shr_enc_valid", enc_valid, 1);

    // SHL 2 with a LOAD presented during RUN (must be ignored)
    send_cmd(C_SHL, 3'd2, 8'h00);
    cmd_valid = 1'b1; cmd_op = C_LOAD; cmd_data = 8'hFF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("shl_ignore_q", q, 8'h04);
    check("shl_ignore_done", done, 1);

    // Zero-amount shift and NOP: q held, two-cycle commands
    send_cmd(C_SHL, 3'd0, 8'h00);
    wait_done(cyc);
    check("amt0_done_cycle", cyc, 2);
    send_cmd(C_NOP, 3'd5, 8'h77);
    wait_done(cyc);
    check("nop_q", q, 8'h04);

    // ROR 4 from 01, reset after two steps
    send_cmd(C_LOAD, 3'd0, 8'h01);
    wait_done(cyc);
    send_cmd(C_ROR, 3'd4, 8'h00);
    @(posedge clk); #1; check("ror_step1", q, 8'h80);
    @(posedge clk); #1; check("ror_step2", q, 8'h40);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("ror_rst_q", q, 8'h09);
    check("ror_rst_done", done, 0);
    check("ror_rst_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = C_LOAD; cmd_data = 8'h5A;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("post_rst_load", q, 8'h5A);
    wait_done(cyc);

    // Bit-select sweep over 5A
    for (int s = 0; s < W; s++) begin
      sel = 3'(s);
      @(negedge clk);
    end

    // Max amount: ROL 7 of 5A equals ROR 1 -> 2D, k+2 = 9 cycles
    send_cmd(C_ROL, 3'd7, 8'h00);
    wait_done(cyc);
    check("rol7_q", q, 8'h2D);
    check("rol7_done_cycle", cyc, 9);

    // Zero register
    send_cmd(C_LOAD, 3'd0, 8'h00);
    wait_done(cyc);
    @(negedge clk);
    check("zero_enc_idx", enc_idx, 0);
    check("zero_enc_valid", enc_valid, 0);

`ifdef SHIFT_PRIO_PIPE_EN
    send_cmd(C_LOAD, 3'd0, 8'h40);
    check("pipe_q", q, 8'h40);
    check("pipe_lag_valid", enc_valid, 0);
    @(posedge clk); #1;
    check("pipe_enc_idx", enc_idx, 6);
    check("pipe_enc_valid", enc_valid, 1);
    wait_done(cyc);
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
